// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC command sequencer: FSM states,
// ICW/OCW bit positions, OCW2 command codes and read-select values.
package pic_pkg;

  typedef enum logic [2:0] {
    UNINIT = 3'd0,
    W_ICW2 = 3'd1,
    W_ICW3 = 3'd2,
    W_ICW4 = 3'd3,
    READY  = 3'd4
  } pic_state_e;

  // OCW2 R/SL/EOI encodings
  localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] OCW2_NSEOI        = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_SEOI         = 3'b011;
  localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS       = 3'b101;
  localparam logic [2:0] OCW2_SET_PRI      = 3'b110;
  localparam logic [2:0] OCW2_ROT_S        = 3'b111;

  // Discriminator and field bit positions within the written byte
  localparam int ICW1_BIT  = 4;
  localparam int OCW3_BIT  = 3;
  localparam int ICW1_LTIM = 3;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_IC4  = 0;
  localparam int OCW3_ESMM = 6;
  localparam int OCW3_SMM  = 5;
  localparam int OCW3_P    = 2;
  localparam int OCW3_RR   = 1;
  localparam int OCW3_RIS  = 0;

  localparam logic RSEL_IRR = 1'b0;
  localparam logic RSEL_ISR = 1'b1;

  // Field order matches ICW4 din[4:0]
  typedef struct packed {
    logic sfnm;
    logic buf_en;
    logic ms;
    logic aeoi;
    logic upm;
  } icw4_t;

  function automatic pic_state_e icw2_next(input logic sngl, input logic ic4);
    if (!sngl)    return W_ICW3;
    else if (ic4) return W_ICW4;
    else          return READY;
  endfunction

endpackage

// File: rtl/pic_bus_edge.sv
// Bus strobe qualification: one-cycle write/read strobes on the rising edge
// of the chip-selected act signals, plus the registered read drive enable.
module pic_bus_edge (
  input  logic clk,
  input  logic reset,
  input  logic cs_n,
  input  logic wr_n,
  input  logic rd_n,
  output logic wr_stb,
  output logic rd_stb,
  output logic dout_oe
);

  logic wr_act, rd_act;
  logic wr_act_q, rd_act_q;

  assign wr_act = ~cs_n & ~wr_n;
  assign rd_act = ~cs_n & ~rd_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_act_q <= 1'b0;
      rd_act_q <= 1'b0;
    end else begin
      wr_act_q <= wr_act;
      rd_act_q <= rd_act;
    end
  end

  // A write rising together with a read wins; the read is dropped.
  assign wr_stb  = wr_act & ~wr_act_q;
  assign rd_stb  = rd_act & ~rd_act_q & ~wr_stb;
  assign dout_oe = rd_act_q;

endmodule

// File: rtl/pic_cmd_seq.sv
// PIC command-word sequencer: ICW1-4 initialisation FSM, OCW1-3 decode,
// configuration registers and IRR/ISR/IMR/poll readback.
module pic_cmd_seq
  import pic_pkg::*;
#(
  parameter int                NUM_IR  = 8,
  parameter logic [NUM_IR-1:0] IMR_RST = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_n,
  input  logic              wr_n,
  input  logic              rd_n,
  input  logic              a0,
  input  logic [7:0]        din,
  input  logic [NUM_IR-1:0] irr_in,
  input  logic [NUM_IR-1:0] isr_in,
  input  logic [7:0]        poll_word,
  output logic [7:0]        dout,
  output logic              dout_oe,
  output logic              init_done,
  output logic              init_pulse,
  output logic              ltim,
  output logic              sngl,
  output logic              ic4,
  output logic [4:0]        vec_base,
  output logic [7:0]        cas_cfg,
  output logic              upm,
  output logic              aeoi,
  output logic              ms,
  output logic              buf_en,
  output logic              sfnm,
  output logic [NUM_IR-1:0] imr,
  output logic              ocw2_stb,
  output logic [2:0]        ocw2_cmd,
  output logic [2:0]        ocw2_lvl,
  output logic              smm,
  output logic              poll_ack
);

  logic       wr_stb, rd_stb;
  pic_state_e state;
  icw4_t      icw4;
  logic       read_sel;
  logic       poll_pend;
  logic [7:0] imr_x, irr_x, isr_x;

  pic_bus_edge u_edge (
    .clk    (clk),
    .reset  (reset),
    .cs_n   (cs_n),
    .wr_n   (wr_n),
    .rd_n   (rd_n),
    .wr_stb (wr_stb),
    .rd_stb (rd_stb),
    .dout_oe(dout_oe)
  );

  always_comb begin
    imr_x = '0;
    irr_x = '0;
    isr_x = '0;
    imr_x[NUM_IR-1:0] = imr;
    irr_x[NUM_IR-1:0] = irr_in;
    isr_x[NUM_IR-1:0] = isr_in;
  end

  assign {sfnm, buf_en, ms, aeoi, upm} = icw4;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= UNINIT;
      dout       <= '0;
      init_done  <= 1'b0;
      init_pulse <= 1'b0;
      ltim       <= 1'b0;
      sngl       <= 1'b0;
      ic4        <= 1'b0;
      vec_base   <= '0;
      cas_cfg    <= '0;
      icw4       <= '0;
      imr        <= IMR_RST;
      ocw2_stb   <= 1'b0;
      ocw2_cmd   <= '0;
      ocw2_lvl   <= '0;
      smm        <= 1'b0;
      poll_ack   <= 1'b0;
      read_sel   <= RSEL_IRR;
      poll_pend  <= 1'b0;
    end else begin
      init_pulse <= 1'b0;
      ocw2_stb   <= 1'b0;
      poll_ack   <= 1'b0;
      if (wr_stb) begin
        // ICW1 restarts initialisation from any state
        if (!a0 && din[ICW1_BIT]) begin
          ltim       <= din[ICW1_LTIM];
          sngl       <= din[ICW1_SNGL];
          ic4        <= din[ICW1_IC4];
          imr        <= IMR_RST;
          icw4       <= '0;
          smm        <= 1'b0;
          read_sel   <= RSEL_IRR;
          init_pulse <= 1'b1;
          init_done  <= 1'b0;
          state      <= W_ICW2;
        end else begin
          case (state)
            W_ICW2: if (a0) begin
              vec_base  <= din[7:3];
              state     <= icw2_next(sngl, ic4);
              init_done <= (icw2_next(sngl, ic4) == READY);
            end
            W_ICW3: if (a0) begin
              cas_cfg   <= din;
              state     <= ic4 ? W_ICW4 : READY;
              init_done <= ~ic4;
            end
            W_ICW4: if (a0) begin
              icw4      <= icw4_t'(din[4:0]);
              state     <= READY;
              init_done <= 1'b1;
            end
            READY: begin
              if (a0) begin
                imr <= din[NUM_IR-1:0];
              end else if (!din[OCW3_BIT]) begin
                ocw2_cmd <= din[7:5];
                ocw2_lvl <= din[2:0];
                ocw2_stb <= 1'b1;
              end else begin
                if (din[OCW3_RR])   read_sel  <= din[OCW3_RIS];
                if (din[OCW3_ESMM]) smm       <= din[OCW3_SMM];
                if (din[OCW3_P])    poll_pend <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end else if (rd_stb) begin
        if (poll_pend) begin
          dout      <= poll_word;
          poll_pend <= 1'b0;
          poll_ack  <= 1'b1;
        end else if (a0) begin
          dout <= imr_x;
        end else begin
          dout <= (read_sel == RSEL_ISR) ? isr_x : irr_x;
        end
      end
    end
  end

endmodule
